// File: rtl/ycrcb_pkg.sv
// Shared types, coefficient sets and clamp helper for the RGB -> YCrCb pipeline.
// Define YCRCB_FULL_RANGE_EN to select full-range coefficients instead of studio range.
package ycrcb_pkg;

    typedef logic signed [17:0] prod_t;
    typedef logic signed [8:0]  coef_t;

    localparam int LATENCY = 3;

    localparam coef_t STD_Y_R  =  9'sd66;
    localparam coef_t STD_Y_G  =  9'sd129;
    localparam coef_t STD_Y_B  =  9'sd25;
    localparam prod_t STD_Y_OF =  18'sd16;
    localparam coef_t STD_CB_R = -9'sd38;
    localparam coef_t STD_CB_G = -9'sd74;
    localparam coef_t STD_CB_B =  9'sd112;
    localparam prod_t STD_CB_OF = 18'sd128;
    localparam coef_t STD_CR_R =  9'sd112;
    localparam coef_t STD_CR_G = -9'sd94;
    localparam coef_t STD_CR_B = -9'sd18;
    localparam prod_t STD_CR_OF = 18'sd128;

    localparam coef_t FUL_Y_R  =  9'sd77;
    localparam coef_t FUL_Y_G  =  9'sd150;
    localparam coef_t FUL_Y_B  =  9'sd29;
    localparam prod_t FUL_Y_OF =  18'sd0;
    localparam coef_t FUL_CB_R = -9'sd43;
    localparam coef_t FUL_CB_G = -9'sd85;
    localparam coef_t FUL_CB_B =  9'sd128;
    localparam prod_t FUL_CB_OF = 18'sd128;
    localparam coef_t FUL_CR_R =  9'sd128;
    localparam coef_t FUL_CR_G = -9'sd107;
    localparam coef_t FUL_CR_B = -9'sd21;
    localparam prod_t FUL_CR_OF = 18'sd128;

`ifdef YCRCB_FULL_RANGE_EN
    localparam coef_t Y_R  = FUL_Y_R;
    localparam coef_t Y_G  = FUL_Y_G;
    localparam coef_t Y_B  = FUL_Y_B;
    localparam prod_t Y_OF = FUL_Y_OF;
    localparam coef_t CB_R = FUL_CB_R;
    localparam coef_t CB_G = FUL_CB_G;
    localparam coef_t CB_B = FUL_CB_B;
    localparam prod_t CB_OF = FUL_CB_OF;
    localparam coef_t CR_R = FUL_CR_R;
    localparam coef_t CR_G = FUL_CR_G;
    localparam coef_t CR_B = FUL_CR_B;
    localparam prod_t CR_OF = FUL_CR_OF;
`else
    localparam coef_t Y_R  = STD_Y_R;
    localparam coef_t Y_G  = STD_Y_G;
    localparam coef_t Y_B  = STD_Y_B;
    localparam prod_t Y_OF = STD_Y_OF;
    localparam coef_t CB_R = STD_CB_R;
    localparam coef_t CB_G = STD_CB_G;
    localparam coef_t CB_B = STD_CB_B;
    localparam prod_t CB_OF = STD_CB_OF;
    localparam coef_t CR_R = STD_CR_R;
    localparam coef_t CR_G = STD_CR_G;
    localparam coef_t CR_B = STD_CR_B;
    localparam prod_t CR_OF = STD_CR_OF;
`endif

    function automatic logic [7:0] clamp_u8(input prod_t v);
        if (v[17]) return 8'd0;
        if (|v[16:8]) return 8'hff;
        return v[7:0];
    endfunction

endpackage

// File: rtl/rgb_to_ycrcb_color_dot3.sv
// One output channel: registered products, rounded sum, then floor-shift,
// offset and clamp to 8 bits. Three register stages.
module color_dot3
    import ycrcb_pkg::*;
#(
    parameter coef_t K_R    = '0,
    parameter coef_t K_G    = '0,
    parameter coef_t K_B    = '0,
    parameter prod_t OFFSET = '0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic [7:0] c_o
);

    prod_t      pr_q, pg_q, pb_q;
    prod_t      sum_q, sum_d;
    prod_t      val_d;
    logic [7:0] c_q, c_d;

    always_comb begin
        sum_d = pr_q + pg_q + pb_q + prod_t'(128);
        val_d = (sum_q >>> 8) + OFFSET;
        c_d   = clamp_u8(val_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pr_q  <= '0;
            pg_q  <= '0;
            pb_q  <= '0;
            sum_q <= '0;
            c_q   <= '0;
        end else begin
            pr_q  <= prod_t'(K_R) * prod_t'({1'b0, r_i});
            pg_q  <= prod_t'(K_G) * prod_t'({1'b0, g_i});
            pb_q  <= prod_t'(K_B) * prod_t'({1'b0, b_i});
            sum_q <= sum_d;
            c_q   <= c_d;
        end
    end

    assign c_o = c_q;

endmodule

// File: rtl/rgb_to_ycrcb.sv
// BT.601 RGB -> YCrCb converter, 3-cycle latency, 1 pixel/clk, no backpressure.
// Build with YCRCB_FULL_RANGE_EN for full-range (JPEG) coefficients.
module rgb_to_ycrcb
    import ycrcb_pkg::*;
#(
    parameter int SIDEBAND_WIDTH = 21
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      valid_in,
    input  logic [7:0]                r_in,
    input  logic [7:0]                g_in,
    input  logic [7:0]                b_in,
    input  logic [SIDEBAND_WIDTH-1:0] sideband_in,
    output logic                      valid_out,
    output logic [7:0]                y_out,
    output logic [7:0]                cr_out,
    output logic [7:0]                cb_out,
    output logic [7:0]                r_out,
    output logic [7:0]                g_out,
    output logic [7:0]                b_out,
    output logic [SIDEBAND_WIDTH-1:0] sideband_out
);

    logic [LATENCY-1:0]        valid_q;
    logic [7:0]                r_q  [LATENCY];
    logic [7:0]                g_q  [LATENCY];
    logic [7:0]                b_q  [LATENCY];
    logic [SIDEBAND_WIDTH-1:0] sb_q [LATENCY];

    color_dot3 #(.K_R(Y_R), .K_G(Y_G), .K_B(Y_B), .OFFSET(Y_OF)) u_y (
        .clk_i(clk_in), .rst_i(rst_in),
        .r_i(r_in), .g_i(g_in), .b_i(b_in), .c_o(y_out)
    );

    color_dot3 #(.K_R(CB_R), .K_G(CB_G), .K_B(CB_B), .OFFSET(CB_OF)) u_cb (
        .clk_i(clk_in), .rst_i(rst_in),
        .r_i(r_in), .g_i(g_in), .b_i(b_in), .c_o(cb_out)
    );

    color_dot3 #(.K_R(CR_R), .K_G(CR_G), .K_B(CR_B), .OFFSET(CR_OF)) u_cr (
        .clk_i(clk_in), .rst_i(rst_in),
        .r_i(r_in), .g_i(g_in), .b_i(b_in), .c_o(cr_out)
    );

    // Delay lines kept in lockstep with the three arithmetic stages
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_q[i]  <= '0;
                g_q[i]  <= '0;
                b_q[i]  <= '0;
                sb_q[i] <= '0;
            end
        end else begin
            valid_q <= {valid_q[LATENCY-2:0], valid_in};
            r_q[0]  <= r_in;
            g_q[0]  <= g_in;
            b_q[0]  <= b_in;
            sb_q[0] <= sideband_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_q[i]  <= r_q[i-1];
                g_q[i]  <= g_q[i-1];
                b_q[i]  <= b_q[i-1];
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    assign valid_out    = valid_q[LATENCY-1];
    assign r_out        = r_q[LATENCY-1];
    assign g_out        = g_q[LATENCY-1];
    assign b_out        = b_q[LATENCY-1];
    assign sideband_out = sb_q[LATENCY-1];

endmodule

// File: tb/tb_rgb_to_ycrcb.sv
// Self-checking bench for rgb_to_ycrcb: directed pixels, random stream,
// and mid-stream reset, with a scoreboard queue of expected outputs.
module tb_rgb_to_ycrcb;

    localparam int SBW = 21;

    typedef struct {
        int y, cb, cr, r, g, b, sb;
    } exp_t;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           valid_in;
    logic [7:0]     r_in, g_in, b_in;
    logic [SBW-1:0] sideband_in;
    logic           valid_out;
    logic [7:0]     y_out, cr_out, cb_out, r_out, g_out, b_out;
    logic [SBW-1:0] sideband_out;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    rgb_to_ycrcb #(.SIDEBAND_WIDTH(SBW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .sideband_in(sideband_in),
        .valid_out(valid_out), .y_out(y_out), .cr_out(cr_out),
        .cb_out(cb_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .sideband_out(sideband_out)
    );

    always #5 clk_in = ~clk_in;

`ifdef YCRCB_FULL_RANGE_EN
    localparam int KY[4]  = '{77, 150, 29, 0};
    localparam int KCB[4] = '{-43, -85, 128, 128};
    localparam int KCR[4] = '{128, -107, -21, 128};
`else
    localparam int KY[4]  = '{66, 129, 25, 16};
    localparam int KCB[4] = '{-38, -74, 112, 128};
    localparam int KCR[4] = '{112, -94, -18, 128};
`endif

    function automatic int model(input int k[4], input int r, g, b);
        int t, q, v;
        t = k[0] * r + k[1] * g + k[2] * b + 128;
        q = (t >= 0) ? t / 256 : -((-t + 255) / 256);
        v = q + k[3];
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int y, cb, cr, r, g, b, sb);
        exp_t e;
        e.y = y; e.cb = cb; e.cr = cr;
        e.r = r; e.g = g; e.b = b; e.sb = sb;
        sb_q.push_back(e);
    endtask

    task automatic drive(input int r, g, b, sb);
        valid_in    = 1'b1;
        r_in        = 8'(r);
        g_in        = 8'(g);
        b_in        = 8'(b);
        sideband_in = SBW'(sb);
    endtask

    task automatic push_model(input int r, g, b, sb);
        push(model(KY, r, g, b), model(KCB, r, g, b), model(KCR, r, g, b),
             r, g, b, sb);
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", int'(valid_out), 0);
            end else begin
                e = sb_q.pop_front();
                chk("y", int'(y_out), e.y);
                chk("cb", int'(cb_out), e.cb);
                chk("cr", int'(cr_out), e.cr);
                chk("r_out", int'(r_out), e.r);
                chk("g_out", int'(g_out), e.g);
                chk("b_out", int'(b_out), e.b);
                chk("sideband", int'(sideband_out), e.sb);
            end
        end
    end

    initial begin
        int r, g, b;
        rst_in      = 1'b1;
        valid_in    = 1'b0;
        r_in        = '0;
        g_in        = '0;
        b_in        = '0;
        sideband_in = '0;

        @(negedge clk_in);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_cb", int'(cb_out), 0);
        chk("rst_cr", int'(cr_out), 0);
        chk("rst_rgb", int'({r_out, g_out, b_out}), 0);
        chk("rst_sb", int'(sideband_out), 0);
        rst_in = 1'b0;

        // Isolated black pixel, with latency probe
        @(negedge clk_in);
`ifdef YCRCB_FULL_RANGE_EN
        push(0, 128, 128, 0, 0, 0, 5);
`else
        push(16, 128, 128, 0, 0, 0, 5);
`endif
        drive(0, 0, 0, 5);
        @(negedge clk_in);
        valid_in = 1'b0;
        chk("lat1", int'(valid_out), 0);
        @(negedge clk_in);
        chk("lat2", int'(valid_out), 0);
        @(negedge clk_in);
        chk("lat3", int'(valid_out), 1);

        // White
        @(negedge clk_in);
`ifdef YCRCB_FULL_RANGE_EN
        push(255, 128, 128, 255, 255, 255, 6);
`else
        push(235, 128, 128, 255, 255, 255, 6);
`endif
        drive(255, 255, 255, 6);
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // Red, exercises negative Cb sum and (full range) Cr clamp
        @(negedge clk_in);
`ifdef YCRCB_FULL_RANGE_EN
        push(77, 85, 255, 255, 0, 0, 7);
`else
        push(82, 90, 240, 255, 0, 0, 7);
`endif
        drive(255, 0, 0, 7);
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (4) @(negedge clk_in);

        // Back-to-back random stream; valid_out must stay high throughout
        for (int i = 0; i < 103; i++) begin
            @(negedge clk_in);
            if (i >= 3) chk("no_bubble", int'(valid_out), 1);
            if (i < 100) begin
                r = int'($urandom_range(0, 255));
                g = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
                push_model(r, g, b, i);
                drive(r, g, b, i);
            end else begin
                valid_in = 1'b0;
            end
        end
        repeat (2) @(negedge clk_in);

        // Three pixels in flight, then async reset: none may emerge
        @(negedge clk_in);
        drive(10, 20, 30, 900);
        @(negedge clk_in);
        drive(40, 50, 60, 901);
        @(negedge clk_in);
        drive(70, 80, 90, 902);
        @(posedge clk_in);
        #1;
        chk("pre_rst_valid", int'(valid_out), 1);
        #1;
        rst_in = 1'b1;
        #1;
        chk("async_rst_valid", int'(valid_out), 0);
        chk("async_rst_y", int'(y_out), 0);
        chk("async_rst_sb", int'(sideband_out), 0);
        @(negedge clk_in);
        valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (8) @(negedge clk_in);

        chk("drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
